// File: rtl/hr_ext_arbiter_pkg.sv
// hr_ext_arbiter_pkg: shared widths and read-return tag type for the holding-register port arbiter
package hr_ext_arbiter_pkg;
  localparam int HR_ADDR_W = 16;
  localparam int HR_DATA_W = 16;
  localparam int HR_ID_W = 3;
  typedef struct packed {
    logic                valid;
    logic [HR_ID_W-1:0]  id;
    logic                oor;
  } hr_tag_t;
endpackage

// File: rtl/hr_ext_arbiter_if.sv
// hr_ext_arbiter_if: client bus (req/we/addr/wdat in, gnt/err/rvalid/rdata out) plus RAM port B (ext_a/ext_d/ext_v out, ext_q in); slave = arbiter side
interface hr_ext_arbiter_if
  import hr_ext_arbiter_pkg::*;
#(parameter int N_REQ = 4);
  logic [N_REQ-1:0]           req, we, gnt, err, rvalid;
  logic [HR_ADDR_W*N_REQ-1:0] addr;
  logic [HR_DATA_W*N_REQ-1:0] wdat;
  logic [HR_DATA_W-1:0]       rdata, ext_d, ext_q;
  logic [HR_ADDR_W-1:0]       ext_a;
  logic                       ext_v;
  modport master (output req, we, addr, wdat, ext_q, input gnt, err, rvalid, rdata, ext_a, ext_d, ext_v);
  modport slave (input req, we, addr, wdat, ext_q, output gnt, err, rvalid, rdata, ext_a, ext_d, ext_v);
endinterface

// File: rtl/hr_ext_arbiter_rr_pick.sv
// hr_ext_arbiter_rr_pick: combinational round-robin picker; in eligible/last, out one-hot win and win_idx, searching from last+1 with wrap
module hr_ext_arbiter_rr_pick
  import hr_ext_arbiter_pkg::*;
#(parameter int N_REQ = 4) (
  input  logic [N_REQ-1:0]   eligible,
  input  logic [HR_ID_W-1:0] last,
  output logic [N_REQ-1:0]   win,
  output logic [HR_ID_W-1:0] win_idx
);
  always_comb begin
    win = '0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (eligible[i] && i == (int'(last) + k) % N_REQ) begin
          win = '0;
          win[i] = 1'b1;
          win_idx = HR_ID_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/hr_ext_arbiter.sv
// hr_ext_arbiter: round-robin sharing of RAM port B among N_REQ clients with range check and tagged read return; ports clk, rst, bus (slave modport)
module hr_ext_arbiter
  import hr_ext_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int RAM_DEPTH = 10,
  parameter int RD_LAT    = 1
) (
  input logic             clk,
  input logic             rst,
  hr_ext_arbiter_if.slave bus
);
  logic [N_REQ-1:0]     elig, win, gnt_q, gnt_d, err_q, err_d;
  logic [HR_ID_W-1:0]   win_idx, last_q, last_d;
  logic [HR_ADDR_W-1:0] a_w, ext_a_q, ext_a_d;
  logic [HR_DATA_W-1:0] d_w, ext_d_q, ext_d_d;
  logic                 we_w, oor, any_w, ext_v_q, ext_v_d;
  hr_tag_t              iss_q, iss_d, ret;
  hr_tag_t              pipe_q [RD_LAT];

  // the client granted this cycle sits out, so one client gets at most every other slot
  assign elig = bus.req & ~gnt_q;

  hr_ext_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .eligible(elig),
    .last(last_q),
    .win(win),
    .win_idx(win_idx)
  );

  always_comb begin
    a_w = '0;
    d_w = '0;
    we_w = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        a_w = bus.addr[HR_ADDR_W*i +: HR_ADDR_W];
        d_w = bus.wdat[HR_DATA_W*i +: HR_DATA_W];
        we_w = bus.we[i];
      end
    end
    any_w = |win;
    oor = (a_w >> RAM_DEPTH) != '0;
    gnt_d = win;
    err_d = oor ? win : '0;
    ext_v_d = we_w & ~oor;
    ext_a_d = any_w && !oor ? a_w : ext_a_q;
    ext_d_d = any_w && !oor ? d_w : ext_d_q;
    last_d = any_w ? win_idx : last_q;
    iss_d.valid = any_w & ~we_w;
    iss_d.id = win_idx;
    iss_d.oor = oor;
  end

  // iss_q lines up with gnt; pipe_q delays it to match the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      err_q <= '0;
      ext_a_q <= '0;
      ext_d_q <= '0;
      ext_v_q <= 1'b0;
      last_q <= HR_ID_W'(N_REQ - 1);
      iss_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      gnt_q <= gnt_d;
      err_q <= err_d;
      ext_a_q <= ext_a_d;
      ext_d_q <= ext_d_d;
      ext_v_q <= ext_v_d;
      last_q <= last_d;
      iss_q <= iss_d;
      pipe_q[0] <= iss_q;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign ret = pipe_q[RD_LAT-1];
  assign bus.gnt = gnt_q;
  assign bus.err = err_q;
  assign bus.ext_a = ext_a_q;
  assign bus.ext_d = ext_d_q;
  assign bus.ext_v = ext_v_q;
  // rst gates the return so a read in flight when reset arrives never answers
  assign bus.rvalid = ret.valid && !rst ? N_REQ'(1) << ret.id : '0;
  assign bus.rdata = ret.valid && !ret.oor && !rst ? bus.ext_q : '0;
endmodule

// File: tb/tb_hr_ext_arbiter.sv
// tb_hr_ext_arbiter: directed checks of the port arbiter at RD_LAT=1 and RD_LAT=3 against small RAM models
module tb_hr_ext_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] mem1 [1024];
  logic [15:0] mem3 [1024];
  logic [15:0] q1, q3a, q3b, q3c;

  hr_ext_arbiter_if #(.N_REQ(4)) b1 ();
  hr_ext_arbiter_if #(.N_REQ(4)) b3 ();

  hr_ext_arbiter #(.N_REQ(4), .RAM_DEPTH(10), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  hr_ext_arbiter #(.N_REQ(4), .RAM_DEPTH(10), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mem1[5] <= 16'hBEEF;
      mem3[1023] <= 16'hCAFE;
    end else begin
      if (b1.ext_v) mem1[b1.ext_a[9:0]] <= b1.ext_d;
      if (b3.ext_v) mem3[b3.ext_a[9:0]] <= b3.ext_d;
    end
    q1 <= mem1[b1.ext_a[9:0]];
    q3a <= mem3[b3.ext_a[9:0]];
    q3b <= q3a;
    q3c <= q3b;
  end

  assign b1.ext_q = q1;
  assign b3.ext_q = q3c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdat = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdat = '0;
    tick();
    tick();
    check("rst_gnt", 32'(b1.gnt), 32'h0);
    check("rst_err", 32'(b1.err), 32'h0);
    check("rst_rvalid", 32'(b1.rvalid), 32'h0);
    check("rst_rdata", 32'(b1.rdata), 32'h0);
    check("rst_ext_a", 32'(b1.ext_a), 32'h0);
    check("rst_ext_d", 32'(b1.ext_d), 32'h0);
    check("rst_ext_v", 32'(b1.ext_v), 32'h0);
    // single read of preloaded address 5
    rst = 1'b0;
    b1.req = 4'b0001; b1.addr = {48'h0, 16'h0005};
    tick();
    check("rd_gnt", 32'(b1.gnt), 32'h1);
    check("rd_ext_a", 32'(b1.ext_a), 32'h5);
    check("rd_ext_v", 32'(b1.ext_v), 32'h0);
    check("rd_rvalid_early", 32'(b1.rvalid), 32'h0);
    b1.req = '0;
    tick();
    check("rd_rvalid", 32'(b1.rvalid), 32'h1);
    check("rd_rdata", 32'(b1.rdata), 32'hBEEF);
    check("rd_gnt_clear", 32'(b1.gnt), 32'h0);
    // four clients writing together: strict rotation 0,1,2,3,0
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    b1.req = 4'hF; b1.we = 4'hF;
    b1.addr = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    b1.wdat = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), 32'(b1.gnt), 32'(1 << (k % 4)));
      check($sformatf("rr_ext_v%0d", k), 32'(b1.ext_v), 32'h1);
      check($sformatf("rr_ext_a%0d", k), 32'(b1.ext_a), 32'h10 + 32'(k % 4));
      check($sformatf("rr_ext_d%0d", k), 32'(b1.ext_d), 32'hA000 + 32'(k % 4));
    end
    b1.req = '0;
    tick();
    check("rr_idle_gnt", 32'(b1.gnt), 32'h0);
    check("rr_idle_v", 32'(b1.ext_v), 32'h0);
    // lone client holding req: every other cycle
    b1.req = 4'b0100; b1.we = 4'b0100;
    b1.addr = {16'h0, 16'h0020, 32'h0}; b1.wdat = {16'h0, 16'h5555, 32'h0};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold_gnt%0d", k), 32'(b1.gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
      check($sformatf("hold_ext_v%0d", k), 32'(b1.ext_v), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    b1.req = '0; b1.we = '0;
    // out-of-range read
    b1.req = 4'b0010; b1.addr = {32'h0, 16'h0400, 16'h0};
    tick();
    check("oor_gnt", 32'(b1.gnt), 32'h2);
    check("oor_err", 32'(b1.err), 32'h2);
    check("oor_ext_v", 32'(b1.ext_v), 32'h0);
    check("oor_ext_a", 32'(b1.ext_a), 32'h20);
    b1.req = '0;
    tick();
    check("oor_rvalid", 32'(b1.rvalid), 32'h2);
    check("oor_rdata", 32'(b1.rdata), 32'h0);
    check("oor_err_clear", 32'(b1.err), 32'h0);
    // write then read-back at RD_LAT=1
    b1.req = 4'b0001; b1.we = 4'b0001;
    b1.addr = {48'h0, 16'h0003}; b1.wdat = {48'h0, 16'h1234};
    tick();
    check("wr1_gnt", 32'(b1.gnt), 32'h1);
    check("wr1_ext_v", 32'(b1.ext_v), 32'h1);
    check("wr1_ext_d", 32'(b1.ext_d), 32'h1234);
    b1.req = 4'b1000; b1.we = '0; b1.addr = {16'h0003, 48'h0};
    tick();
    check("rb1_gnt", 32'(b1.gnt), 32'h8);
    check("rb1_ext_a", 32'(b1.ext_a), 32'h3);
    check("rb1_ext_v", 32'(b1.ext_v), 32'h0);
    b1.req = '0;
    tick();
    check("rb1_rvalid", 32'(b1.rvalid), 32'h8);
    check("rb1_rdata", 32'(b1.rdata), 32'h1234);
    // same at RD_LAT=3 with a second read in flight behind it
    b3.req = 4'b0001; b3.we = 4'b0001;
    b3.addr = {48'h0, 16'h0003}; b3.wdat = {48'h0, 16'h1234};
    tick();
    check("wr3_gnt", 32'(b3.gnt), 32'h1);
    check("wr3_ext_v", 32'(b3.ext_v), 32'h1);
    b3.req = 4'b1000; b3.we = '0; b3.addr = {16'h0003, 48'h0};
    tick();
    check("rb3_gnt3", 32'(b3.gnt), 32'h8);
    b3.req = 4'b0010; b3.addr = {32'h0, 16'h03FF, 16'h0};
    tick();
    check("rb3_gnt1", 32'(b3.gnt), 32'h2);
    check("rb3_rvalid_lat1", 32'(b3.rvalid), 32'h0);
    b3.req = '0;
    tick();
    check("rb3_rvalid_lat2", 32'(b3.rvalid), 32'h0);
    tick();
    check("rb3_rvalid3", 32'(b3.rvalid), 32'h8);
    check("rb3_rdata3", 32'(b3.rdata), 32'h1234);
    tick();
    check("rb3_rvalid1", 32'(b3.rvalid), 32'h2);
    check("rb3_rdata1", 32'(b3.rdata), 32'hCAFE);
    tick();
    check("rb3_rvalid_done", 32'(b3.rvalid), 32'h0);
    // reset while a read is in flight
    b1.req = 4'b0001; b1.we = '0; b1.addr = {48'h0, 16'h0005};
    tick();
    check("mr_gnt", 32'(b1.gnt), 32'h1);
    b1.req = '0;
    tick();
    rst = 1'b1;
    #1;
    check("mr_rvalid_in_rst", 32'(b1.rvalid), 32'h0);
    check("mr_rdata_in_rst", 32'(b1.rdata), 32'h0);
    tick();
    check("mr_gnt_after", 32'(b1.gnt), 32'h0);
    check("mr_err_after", 32'(b1.err), 32'h0);
    check("mr_rvalid_after", 32'(b1.rvalid), 32'h0);
    check("mr_rdata_after", 32'(b1.rdata), 32'h0);
    check("mr_ext_a_after", 32'(b1.ext_a), 32'h0);
    check("mr_ext_d_after", 32'(b1.ext_d), 32'h0);
    check("mr_ext_v_after", 32'(b1.ext_v), 32'h0);
    rst = 1'b0;
    b1.req = 4'b0011; b1.addr = {32'h0, 16'h0006, 16'h0005};
    tick();
    check("mr_first_win", 32'(b1.gnt), 32'h1);
    b1.req = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hr_ext_arbiter.md
# hr_ext_arbiter

Round-robin arbiter sharing the holding-register RAM's external port (`ext_a`/`ext_d`/`ext_v`/`ext_q` of the Modbus RTU slave) between `N_REQ` on-chip clients, such as a sensor scanner, a config loader and a debug bridge. It issues at most one RAM access per cycle and tags each read so the data returns to the client that issued it. Out-of-range addresses are filtered and flagged. It sits between the clients and the slave's second memory port.

## Interface
- `N_REQ`, default 4: number of clients, 2..8.
- `RAM_DEPTH`, default 10: holding-register RAM address bits; valid addresses are 0..2^RAM_DEPTH-1.
- `RD_LAT`, default 1: RAM read latency in cycles from `ext_a` to `ext_q`, 1..3.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-client request level.
- `we`  in  N_REQ  per-client write flag: 1 = write, 0 = read.
- `addr`  in  16*N_REQ  per-client address; client i uses bits [16i+15:16i].
- `wdat`  in  16*N_REQ  per-client write data, same packing as `addr`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: client i's access was issued this cycle.
- `err`  out  N_REQ  one-cycle pulse alongside `gnt`: the address was out of range, so no RAM access took place.
- `rvalid`  out  N_REQ  one-hot, one-cycle pulse: `rdata` belongs to client i.
- `rdata`  out  16  read data, shared by all clients.
- `ext_a`  out  16  RAM port B address.
- `ext_d`  out  16  RAM port B write data.
- `ext_v`  out  1  RAM port B write enable.
- `ext_q`  in  16  RAM port B read data.

## Operation
- Arbitration happens in cycle t over the eligible set: `req` masked by the client currently granted (`gnt` high in cycle t).
- Round-robin search starts at the client after `last`, the most recently granted client, and wraps from N_REQ-1 to 0.
- The winner is registered. In cycle t+1 `ext_a`/`ext_d`/`ext_v` are driven from the winner's `addr`/`wdat`/`we` as sampled in cycle t, and the winner's `gnt` is pulsed.
- Clients hold `req`/`we`/`addr`/`wdat` stable until `gnt`. A client may keep `req` high to queue another access. Because of the grant mask, its request in the grant cycle is ignored, so the same client gets at most one access every 2 cycles.
- Range check: if `addr[15:RAM_DEPTH]` is non-zero, `ext_v`=0, `ext_a`/`ext_d` hold their previous values, and `gnt` and `err` pulse together.
- Issued reads, including out-of-range ones, push a tag `{valid, id, oor}` into an RD_LAT-deep shift register.
  - RD_LAT cycles after issue, `rvalid[id]` pulses.
  - `rdata` = `ext_q`, or 16'h0000 if `oor` is set.
- Writes produce no `rvalid`.
- No request pending in a cycle: `ext_v`=0 and `last` is unchanged.
- A client dropping `req` before it is granted abandons the request; no response is owed.
- Reset values: `gnt`/`err`/`rvalid` = 0, `rdata` = 0, `ext_a`/`ext_d` = 0, `ext_v` = 0, `last` = N_REQ-1 (client 0 has priority first), tag pipe cleared.
- Reset mid-operation: in-flight reads are dropped and no `rvalid` is issued for them.

## Timing
- Request to grant: 1 cycle, with the port driven in the same cycle as `gnt`.
- Request to read data: 1+RD_LAT cycles.
- Peak throughput: 1 access per cycle across different clients.
- Starvation bound: a held request is granted within N_REQ cycles.
- `ext_v` is high for exactly one cycle per write.
- Simultaneous events are independent: `gnt` for one client and `rvalid` for another (or the same) client may pulse in the same cycle.

## Structure
- Shared package (`types`):
  - `HR_ADDR_W` = 16 and `HR_DATA_W` = 16 constants.
  - `hr_tag_t` struct `{valid, id[2:0], oor}` for the read-return pipe.
- Sub-module `rr_pick`: combinational round-robin one-hot picker. Inputs `eligible[N_REQ]` and `last` index; outputs one-hot `win` and `win_idx`. This keeps the registered control in `hr_ext_arbiter`.

## Test plan
- Reset, then client 0 reads 0x0005 with the RAM preloaded so address 5 holds 0xBEEF → `gnt[0]` at t+1, `ext_a`=0x0005, `ext_v`=0, `rvalid[0]` and `rdata`=0xBEEF at t+2 (RD_LAT=1).
- Clients 0..3 all hold write requests from the same cycle → grants issued in order 0,1,2,3, then 0 again, one grant per cycle, never two in one cycle. Each `ext_v` pulse carries the matching `wdat`.
- Client 2 alone holds `req` continuously → grants every other cycle, `ext_v` toggles 1,0,1,0.
- Client 1 reads 0x0400 (out of range with RAM_DEPTH=10) → `gnt[1]`+`err[1]`, `ext_v`=0, `ext_a` unchanged, `rvalid[1]` with `rdata`=0x0000 after RD_LAT.
- Client 0 write 0x0003←0x1234, then client 3 read 0x0003 issued back-to-back → `rvalid[3]`, `rdata`=0x1234. Repeat with RD_LAT=3 and check tags stay aligned.
- `rst` asserted in the cycle after a read grant → no `rvalid`, all outputs 0 the next cycle, and client 0 wins the first arbitration after reset.
